// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid-buffered pipeline stage register with flush and stall counter
//
// Purpose:
//   Registers one pipeline stage's control and data payload between an upstream
//   and a downstream valid/ready handshake. An output register (OUT) feeds the
//   downstream side. A skid register (SKID) catches the entry that arrives in the
//   cycle the downstream side first back-pressures. As a result, up_ready_o is a
//   plain register and carries no combinational path from dn_ready_i.
//
// Parameters:
//   DATA_W    datapath payload width
//   CTRL_W    control payload width
//   CTRL_NOP  control value shown for a bubble, a flushed stage or an empty stage
//   CNT_W     stall counter width
//
// Ports:
//   clk_i        in   1       rising-edge clock
//   rst_i        in   1       asynchronous active-low reset
//   flush_i      in   1       discard held and incoming entries this cycle
//   up_valid_i   in   1       upstream entry valid
//   up_ready_o   out  1       stage can accept an entry (NOT SKID.valid)
//   up_ctrl_i    in   CTRL_W  upstream control payload
//   up_data_i    in   DATA_W  upstream data payload
//   dn_valid_o   out  1       downstream entry valid (OUT.valid)
//   dn_ready_i   in   1       downstream accepts the entry
//   dn_ctrl_o    out  CTRL_W  downstream control payload (CTRL_NOP when empty)
//   dn_data_o    out  DATA_W  downstream data payload (0 when empty)
//   occupancy_o  out  2       held entries, 0..2, registered
//   stall_cnt_o  out  CNT_W   saturating count of back-pressured cycles

module pipe_stage_reg #(
    parameter int                 DATA_W   = 96,
    parameter int                 CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = {CTRL_W{1'b0}},
    parameter int                 CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage storage
    logic              r_out_valid;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [DATA_W-1:0] r_out_data;
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [1:0]        r_occupancy;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Next-state values
    logic              w_accept;
    logic              w_out_free;
    logic              w_stall;
    logic              w_out_valid_nxt;
    logic [CTRL_W-1:0] w_out_ctrl_nxt;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              w_skid_valid_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [1:0]        w_occupancy_nxt;
    logic [CNT_W-1:0]  w_stall_cnt_nxt;

    // Readiness comes only from SKID. A full SKID therefore blocks every accept,
    // so an incoming entry can never overwrite a held entry.
    assign w_accept   = up_valid_i & ~r_skid_valid;
    // OUT can take a new entry when it is empty or is handing its entry off this edge.
    assign w_out_free = ~r_out_valid | dn_ready_i;
    assign w_stall    = r_out_valid & ~dn_ready_i;

    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_ctrl_nxt   = r_out_ctrl;
        w_out_data_nxt   = r_out_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_ctrl_nxt  = r_skid_ctrl;
        w_skid_data_nxt  = r_skid_data;

        if (flush_i) begin
            // Flush outranks accept and deliver. Anything presented this cycle is dropped.
            w_out_valid_nxt  = 1'b0;
            w_out_ctrl_nxt   = CTRL_NOP;
            w_out_data_nxt   = '0;
            w_skid_valid_nxt = 1'b0;
            w_skid_ctrl_nxt  = '0;
            w_skid_data_nxt  = '0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // The older entry in SKID moves up first so that order is preserved.
                w_out_valid_nxt  = 1'b1;
                w_out_ctrl_nxt   = r_skid_ctrl;
                w_out_data_nxt   = r_skid_data;
                w_skid_valid_nxt = w_accept;
                w_skid_ctrl_nxt  = w_accept ? up_ctrl_i : '0;
                w_skid_data_nxt  = w_accept ? up_data_i : '0;
            end else if (w_accept) begin
                w_out_valid_nxt  = 1'b1;
                w_out_ctrl_nxt   = up_ctrl_i;
                w_out_data_nxt   = up_data_i;
            end else begin
                // When OUT empties, its payload is driven to the bubble value so
                // downstream logic that ignores valid still sees a NOP.
                w_out_valid_nxt  = 1'b0;
                w_out_ctrl_nxt   = CTRL_NOP;
                w_out_data_nxt   = '0;
            end
        end else if (w_accept) begin
            // OUT is held, so the new entry parks in SKID.
            w_skid_valid_nxt = 1'b1;
            w_skid_ctrl_nxt  = up_ctrl_i;
            w_skid_data_nxt  = up_data_i;
        end

        w_occupancy_nxt = {1'b0, w_out_valid_nxt} + {1'b0, w_skid_valid_nxt};

        // Flush does not affect the stall count. It measures back-pressure, not pipeline content.
        w_stall_cnt_nxt = r_stall_cnt;
        if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            w_stall_cnt_nxt = r_stall_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_out_valid  <= 1'b0;
            r_out_ctrl   <= CTRL_NOP;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
            r_occupancy  <= 2'd0;
            r_stall_cnt  <= '0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out_ctrl   <= w_out_ctrl_nxt;
            r_out_data   <= w_out_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_ctrl  <= w_skid_ctrl_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_occupancy  <= w_occupancy_nxt;
            r_stall_cnt  <= w_stall_cnt_nxt;
        end
    end

    // Every output is driven straight from a register.
    assign up_ready_o  = ~r_skid_valid;
    assign dn_valid_o  = r_out_valid;
    assign dn_ctrl_o   = r_out_ctrl;
    assign dn_data_o   = r_out_data;
    assign occupancy_o = r_occupancy;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed table, corner sequences and random scoreboard for pipe_stage_reg

module tb_pipe_stage_reg;

    localparam int         DW  = 96;
    localparam int         CW  = 8;
    localparam int         NW  = 4;
    localparam logic [7:0] NOP = 8'h5A;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          up_valid_i;
    logic          up_ready_o;
    logic [CW-1:0] up_ctrl_i;
    logic [DW-1:0] up_data_i;
    logic          dn_valid_o;
    logic          dn_ready_i;
    logic [CW-1:0] dn_ctrl_o;
    logic [DW-1:0] dn_data_o;
    logic [1:0]    occupancy_o;
    logic [NW-1:0] stall_cnt_o;

    pipe_stage_reg #(
        .DATA_W   (DW),
        .CTRL_W   (CW),
        .CTRL_NOP (NOP),
        .CNT_W    (NW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .up_valid_i  (up_valid_i),
        .up_ready_o  (up_ready_o),
        .up_ctrl_i   (up_ctrl_i),
        .up_data_i   (up_data_i),
        .dn_valid_o  (dn_valid_o),
        .dn_ready_i  (dn_ready_i),
        .dn_ctrl_o   (dn_ctrl_o),
        .dn_data_o   (dn_data_o),
        .occupancy_o (occupancy_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [95:0] ed,
                              input logic [7:0] ec, input logic eur, input logic [1:0] eocc,
                              input logic [3:0] estall);
        chk({tag, ".dn_valid"},  128'(dn_valid_o),  128'(ev));
        chk({tag, ".dn_data"},   128'(dn_data_o),   128'(ed));
        chk({tag, ".dn_ctrl"},   128'(dn_ctrl_o),   128'(ec));
        chk({tag, ".up_ready"},  128'(up_ready_o),  128'(eur));
        chk({tag, ".occupancy"}, 128'(occupancy_o), 128'(eocc));
        chk({tag, ".stall_cnt"}, 128'(stall_cnt_o), 128'(estall));
    endtask

    typedef struct {
        logic        flush;
        logic        up_valid;
        logic        dn_ready;
        logic [95:0] din;
        logic        e_valid;
        logic [95:0] e_data;
        logic        e_ready;
        logic [1:0]  e_occ;
        logic [3:0]  e_stall;
    } vec_t;

    function automatic vec_t mk(input logic fl, input logic uv, input logic dr, input logic [95:0] din,
                                input logic ev, input logic [95:0] ed, input logic eur,
                                input logic [1:0] eocc, input logic [3:0] es);
        vec_t v;
        v.flush = fl; v.up_valid = uv; v.dn_ready = dr; v.din = din;
        v.e_valid = ev; v.e_data = ed; v.e_ready = eur; v.e_occ = eocc; v.e_stall = es;
        return v;
    endfunction

    vec_t tv[17];

    // Each input's ctrl payload is the low byte of its data. Expected outputs are sampled after the edge.
    task automatic drive(input logic fl, input logic uv, input logic dr, input logic [95:0] din);
        flush_i    = fl;
        up_valid_i = uv;
        dn_ready_i = dr;
        up_data_i  = din;
        up_ctrl_i  = din[7:0];
    endtask

    logic [103:0] q[$];
    int           stall_m;
    logic         acc, del;
    logic [95:0]  rd;
    logic [7:0]   rc;

    initial begin
        //               fl uv dr din      ev edata   rdy occ stall
        tv[0]  = mk(0, 1, 1, 96'h1,  1, 96'h1,  1, 2'd1, 4'd0);   // stream A
        tv[1]  = mk(0, 1, 1, 96'h2,  1, 96'h2,  1, 2'd1, 4'd0);   // stream B
        tv[2]  = mk(0, 1, 1, 96'h3,  1, 96'h3,  1, 2'd1, 4'd0);   // stream C
        tv[3]  = mk(0, 0, 1, 96'h0,  0, 96'h0,  1, 2'd0, 4'd0);   // drain
        tv[4]  = mk(0, 1, 0, 96'hA,  1, 96'hA,  1, 2'd1, 4'd0);   // bp A into empty stage, no stall yet
        tv[5]  = mk(0, 1, 0, 96'hB,  1, 96'hA,  0, 2'd2, 4'd1);   // bp B to skid
        tv[6]  = mk(0, 1, 0, 96'hC,  1, 96'hA,  0, 2'd2, 4'd2);   // full: C ignored
        tv[7]  = mk(0, 0, 1, 96'h0,  1, 96'hB,  1, 2'd1, 4'd2);   // A leaves, B moves up
        tv[8]  = mk(0, 0, 1, 96'h0,  0, 96'h0,  1, 2'd0, 4'd2);   // B leaves
        tv[9]  = mk(0, 1, 0, 96'h21, 1, 96'h21, 1, 2'd1, 4'd2);   // flush setup A
        tv[10] = mk(0, 1, 0, 96'h22, 1, 96'h21, 0, 2'd2, 4'd3);   // flush setup B
        tv[11] = mk(1, 1, 0, 96'h23, 0, 96'h0,  1, 2'd0, 4'd4);   // flush with C present
        tv[12] = mk(0, 0, 1, 96'h0,  0, 96'h0,  1, 2'd0, 4'd4);   // C never appears
        tv[13] = mk(1, 1, 1, 96'h31, 0, 96'h0,  1, 2'd0, 4'd4);   // flush beats accept into empty stage
        tv[14] = mk(0, 1, 0, 96'h41, 1, 96'h41, 1, 2'd1, 4'd4);
        tv[15] = mk(1, 1, 1, 96'h42, 0, 96'h0,  1, 2'd0, 4'd4);   // flush beats deliver and accept
        tv[16] = mk(0, 0, 1, 96'h0,  0, 96'h0,  1, 2'd0, 4'd4);

        rst_i = 1'b0;
        drive(0, 0, 1, 96'h0);
        repeat (2) @(posedge clk_i);
        #1 check_outs("reset", 0, 96'h0, NOP, 1, 2'd0, 4'd0);
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i);
        #1 check_outs("post_reset", 0, 96'h0, NOP, 1, 2'd0, 4'd0);

        for (int i = 0; i < 17; i++) begin
            drive(tv[i].flush, tv[i].up_valid, tv[i].dn_ready, tv[i].din);
            @(posedge clk_i);
            #1 check_outs($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_data,
                          tv[i].e_valid ? tv[i].e_data[7:0] : NOP,
                          tv[i].e_ready, tv[i].e_occ, tv[i].e_stall);
        end

        // Saturation: hold one entry under back-pressure for 20 cycles.
        drive(0, 1, 0, 96'h51);
        @(posedge clk_i);
        #1 check_outs("sat_load", 1, 96'h51, 8'h51, 1, 2'd1, 4'd4);
        drive(0, 0, 0, 96'h0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_i);
            #1 chk($sformatf("sat_stall%0d", k), 128'(stall_cnt_o), 128'((4 + k > 15) ? 15 : 4 + k));
        end
        drive(1, 0, 0, 96'h0);
        @(posedge clk_i);
        #1 check_outs("sat_flush", 0, 96'h0, NOP, 1, 2'd0, 4'd15);

        // Async reset with both registers full, asserted between clock edges.
        drive(0, 1, 0, 96'h61);
        @(posedge clk_i);
        #1 drive(0, 1, 0, 96'h62);
        @(posedge clk_i);
        #1 check_outs("arst_full", 1, 96'h61, 8'h61, 0, 2'd2, 4'd15);
        drive(0, 0, 1, 96'h0);
        #2 rst_i = 1'b0;
        #1 check_outs("arst_now", 0, 96'h0, NOP, 1, 2'd0, 4'd0);
        @(negedge clk_i) rst_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1 check_outs($sformatf("arst_after%0d", k), 0, 96'h0, NOP, 1, 2'd0, 4'd0);
        end

        // Random traffic against a 2-entry FIFO model.
        stall_m = 0;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            rd = {$urandom, $urandom, $urandom};
            rc = 8'($urandom);
            flush_i    = ($urandom_range(0, 99) < 4);
            up_valid_i = ($urandom_range(0, 99) < 60);
            dn_ready_i = ($urandom_range(0, 99) < 60);
            up_data_i  = rd;
            up_ctrl_i  = rc;
            #1;
            chk("rnd.dn_valid",  128'(dn_valid_o),  128'(q.size() != 0));
            chk("rnd.up_ready",  128'(up_ready_o),  128'(q.size() < 2));
            chk("rnd.occupancy", 128'(occupancy_o), 128'(q.size()));
            chk("rnd.stall_cnt", 128'(stall_cnt_o), 128'(stall_m));
            if (q.size() != 0) begin
                chk("rnd.dn_data", 128'(dn_data_o), 128'(q[0][95:0]));
                chk("rnd.dn_ctrl", 128'(dn_ctrl_o), 128'(q[0][103:96]));
            end else begin
                chk("rnd.dn_data_empty", 128'(dn_data_o), 128'(0));
                chk("rnd.dn_ctrl_empty", 128'(dn_ctrl_o), 128'(NOP));
            end
            acc = up_valid_i && (q.size() < 2);
            del = (q.size() != 0) && dn_ready_i;
            if ((q.size() != 0) && !dn_ready_i && stall_m < 15) stall_m++;
            if (flush_i) begin
                q.delete();
            end else begin
                if (del) void'(q.pop_front());
                if (acc) q.push_back({rc, rd});
            end
            @(posedge clk_i);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 96, datapath payload width (operands, immediate, PCs).
REQ-002 Parameter CTRL_W, default 8, control payload width (RegWrite, MemRead, ALUOp, ...).
REQ-003 Parameter CTRL_NOP, default {CTRL_W{1'b0}}, control value presented for a bubble, flush or empty stage.
REQ-004 Parameter CNT_W, default 16, stall counter width.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset: clk_i in 1, rising-edge clock; rst_i in 1, asynchronous active-low reset.
REQ-006 flush_i  in  1  discard all held and incoming entries this cycle.
REQ-007 up_valid_i  in  1  upstream entry valid.
REQ-008 up_ready_o  out  1  stage can accept an entry.
REQ-009 up_ctrl_i  in  CTRL_W  upstream control payload.
REQ-010 up_data_i  in  DATA_W  upstream data payload.
REQ-011 dn_valid_o  out  1  downstream entry valid.
REQ-012 dn_ready_i  in  1  downstream accepts the entry.
REQ-013 dn_ctrl_o  out  CTRL_W  downstream control payload.
REQ-014 dn_data_o  out  DATA_W  downstream data payload.
REQ-015 occupancy_o  out  2  number of held entries, 0..2.
REQ-016 stall_cnt_o  out  CNT_W  saturating count of back-pressured cycles.

Function
REQ-017 Storage SHALL be an output register (OUT) plus one skid register (SKID), each with its own valid bit; all outputs SHALL come directly from registers.
REQ-018 up_ready_o SHALL equal NOT SKID.valid and SHALL NOT depend combinationally on dn_ready_i.
REQ-019 Accept SHALL occur when up_valid_i and up_ready_o are both high at a rising edge; deliver SHALL occur when dn_valid_o and dn_ready_i are both high.
REQ-020 dn_valid_o, dn_ctrl_o and dn_data_o SHALL reflect OUT; when OUT.valid=0, dn_ctrl_o SHALL be CTRL_NOP and dn_data_o SHALL be 0.
REQ-021 When OUT is empty or delivered this cycle: OUT SHALL load from SKID if SKID.valid, else from the accepted input, else become empty.
REQ-022 When OUT is held (valid, not delivered) and an input is accepted, the input SHALL go to SKID.
REQ-023 When SKID moves into OUT and an input is accepted the same cycle, the input SHALL go to SKID.
REQ-024 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush.
REQ-025 Latency SHALL be 1 cycle from accept into an empty stage to dn_valid_o=1; sustained throughput SHALL be 1 entry/cycle while dn_ready_i=1.
REQ-026 flush_i=1 SHALL clear OUT.valid and SKID.valid at the next edge, force OUT control to CTRL_NOP and data to 0, and discard any input accepted that cycle; flush SHALL take priority over accept and deliver.
REQ-027 occupancy_o SHALL equal OUT.valid + SKID.valid, registered.
REQ-028 stall_cnt_o SHALL increment by 1 on each edge where dn_valid_o=1 and dn_ready_i=0, SHALL saturate at 2^CNT_W-1, and SHALL be unaffected by flush_i.
REQ-029 An accept with SKID full is impossible by construction; up_valid_i while up_ready_o=0 SHALL leave state unchanged.

Reset
REQ-030 rst_i=0 SHALL asynchronously set OUT.valid=0, SKID.valid=0, OUT control=CTRL_NOP, OUT data=0, SKID contents=0, occupancy_o=0, stall_cnt_o=0.
REQ-031 During and after reset until the first accept, up_ready_o SHALL be 1 and dn_valid_o 0.
REQ-032 Reset asserted mid-transfer SHALL discard all held entries; no entry SHALL appear on dn_* after release without a new accept.

Verification
REQ-033 Stream: DATA_W=96, dn_ready_i=1, accept A=0x1, B=0x2, C=0x3 in consecutive cycles -> dn_data_o 0x1, 0x2, 0x3 on the next three cycles, occupancy_o<=1, stall_cnt_o=0.
REQ-034 Back-pressure: accept A, B with dn_ready_i=0 -> occupancy_o=2, up_ready_o=0, stall_cnt_o increments each cycle; raise dn_ready_i -> A then B delivered, up_ready_o=1 one cycle after A leaves.
REQ-035 Flush: OUT=A, SKID=B, flush_i=1 with up_valid_i=1 data C -> next cycle dn_valid_o=0, dn_ctrl_o=CTRL_NOP, occupancy_o=0, C never delivered.
REQ-036 Saturation: CNT_W=4, hold dn_ready_i=0 with OUT valid for 20 cycles -> stall_cnt_o stops at 15.
REQ-037 Async reset: occupancy_o=2, drop rst_i between clock edges -> all outputs at REQ-030 values immediately; after release, dn_valid_o stays 0 until a new accept.
REQ-038 Random: random up_valid_i/dn_ready_i/flush_i for 10000 cycles against a 2-entry FIFO scoreboard -> zero order, loss or duplication errors.
